// File: rtl/cpu_core_mc_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states, flag
// positions in the status register and branch-condition codes.
package cpu_core_mc_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_AND    = 3'd1,
    OP_NOT    = 3'd2,
    OP_LOAD   = 3'd3,
    OP_STORE  = 3'd4,
    OP_JUMP   = 3'd5,
    OP_BRANCH = 3'd6,
    OP_OUT    = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_LOADWB = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_V = 2;
  localparam int FLG_N = 3;

  localparam logic [1:0] BR_Z      = 2'b00;
  localparam logic [1:0] BR_C      = 2'b01;
  localparam logic [1:0] BR_N      = 2'b10;
  localparam logic [1:0] BR_ALWAYS = 2'b11;

  function automatic logic isAluOp(input opcode_e op);
    return (op == OP_ADD) || (op == OP_AND) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/cpu_core_mc_alu.sv
// Combinational ALU for the multi-cycle core: result plus the four status
// flags; flags are only meaningful for ADD/AND/NOT.
module cpu_alu_mc
  import cpu_core_mc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  opcode_e           i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_res,
  output logic [3:0]        o_flags
);

  logic [DATA_W:0] w_sum;

  always_comb begin
    w_sum   = {1'b0, i_a} + {1'b0, i_b};
    o_res   = '0;
    o_flags = '0;
    case (i_op)
      OP_ADD: begin
        o_res          = w_sum[DATA_W-1:0];
        o_flags[FLG_C] = w_sum[DATA_W];
        // Signed overflow: operands agree in sign but the result does not.
        o_flags[FLG_V] = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                         (w_sum[DATA_W-1] != i_a[DATA_W-1]);
      end
      OP_AND:  o_res = i_a & i_b;
      OP_NOT:  o_res = ~i_a;
      default: o_res = '0;
    endcase
    o_flags[FLG_Z] = (o_res == '0);
    o_flags[FLG_N] = o_res[DATA_W-1];
  end

endmodule

// File: rtl/cpu_core_mc.sv
// Parametrised multi-cycle core: FETCH/DECODE/EXEC FSM, register file, PC,
// external synchronous memory port and a valid/ready output channel.
module cpu_core_mc
  import cpu_core_mc_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 8,
  parameter int NREGS    = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              halted
);

  localparam int RS    = $clog2(NREGS);
  localparam int OFF_W = DATA_W - 3 - RS;

  state_e            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [DATA_W-1:0] r_ir;
  logic [3:0]        r_sr;
  logic [DATA_W-1:0] r_regs [NREGS];

  opcode_e           w_op;
  logic [RS-1:0]     w_rd;
  logic [RS-1:0]     w_rs1;
  logic [RS-1:0]     w_rs2;
  logic [OFF_W-1:0]  w_off;
  logic [1:0]        w_brCond;
  logic              w_haltBit;
  logic [DATA_W-1:0] w_rdVal;
  logic [ADDR_W-1:0] w_memOffAddr;
  logic [ADDR_W-1:0] w_jumpAddr;
  logic [ADDR_W-1:0] w_branchAddr;
  logic              w_brTaken;
  logic [DATA_W-1:0] w_aluRes;
  logic [3:0]        w_aluFlags;

  assign w_op      = opcode_e'(r_ir[DATA_W-1 -: 3]);
  assign w_rd      = r_ir[DATA_W-4 -: RS];
  assign w_rs1     = r_ir[DATA_W-4-RS -: RS];
  assign w_rs2     = r_ir[DATA_W-4-2*RS -: RS];
  assign w_off     = r_ir[OFF_W-1:0];
  assign w_brCond  = w_off[OFF_W-1 -: 2];
  assign w_haltBit = w_off[OFF_W-1];
  assign w_rdVal   = r_regs[w_rd];

  // Address sums are taken mod 2^ADDR_W, so truncating each operand first is exact.
  assign w_memOffAddr = r_pc + ADDR_W'(w_off);
  assign w_jumpAddr   = ADDR_W'(w_rdVal) + ADDR_W'(w_off);
  assign w_branchAddr = ADDR_W'(w_rdVal) + ADDR_W'(w_off[OFF_W-3:0]);

  always_comb begin
    w_brTaken = 1'b0;
    case (w_brCond)
      BR_Z:      w_brTaken = r_sr[FLG_Z];
      BR_C:      w_brTaken = r_sr[FLG_C];
      BR_N:      w_brTaken = r_sr[FLG_N];
      BR_ALWAYS: w_brTaken = 1'b1;
      default:   w_brTaken = 1'b0;
    endcase
  end

  cpu_alu_mc #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_op    (w_op),
    .i_a     (r_regs[w_rs1]),
    .i_b     (r_regs[w_rs2]),
    .o_res   (w_aluRes),
    .o_flags (w_aluFlags)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_pc    <= ADDR_W'(RESET_PC);
      r_ir    <= '0;
      r_sr    <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_ir    <= mem_rdata;
          r_pc    <= r_pc + ADDR_W'(1);
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_state <= S_FETCH;
          if (isAluOp(w_op)) begin
            r_regs[w_rd] <= w_aluRes;
            r_sr         <= w_aluFlags;
          end
          case (w_op)
            OP_LOAD:   r_state <= S_LOADWB;
            OP_JUMP:   r_pc    <= w_jumpAddr;
            OP_BRANCH: if (w_brTaken) r_pc <= w_branchAddr;
            OP_OUT: begin
              // OUT holds EXEC until the sink accepts; HALT shares the opcode.
              if (w_haltBit)       r_state <= S_HALT;
              else if (!out_ready) r_state <= S_EXEC;
            end
            default: ;
          endcase
        end
        S_LOADWB: begin
          r_regs[w_rd] <= mem_rdata;
          r_state      <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_addr  = r_pc;
    mem_we    = 1'b0;
    mem_wdata = '0;
    out_valid = 1'b0;
    out_data  = '0;
    if (r_state == S_EXEC) begin
      case (w_op)
        OP_LOAD: mem_addr = w_memOffAddr;
        OP_STORE: begin
          mem_addr  = w_memOffAddr;
          mem_we    = 1'b1;
          mem_wdata = w_rdVal;
        end
        OP_OUT: begin
          if (!w_haltBit) begin
            out_valid = 1'b1;
            out_data  = w_rdVal;
          end
        end
        default: ;
      endcase
    end
  end

  assign halted = (r_state == S_HALT);

endmodule
